cve2_alu_resp_monitor: RTL and testbench

- Downstream consumer of the cve2 ALU in the ALU test harness.
- Each cycle that a stimulus vector is applied, it samples the ALU response: result, adder result, comparison flags and intermediate-value writes.
- It folds every sampled response into a 32-bit MISR signature and counts vectors.
- When the programmed vector count is reached, it compares the signature with an expected value and reports pass/fail.

---
 rtl/cve2_alu_resp_monitor.sv | 121 ++++++++++++
 tb/tb_cve2_alu_resp_monitor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_alu_resp_monitor.sv
// ALU response monitor: folds each sampled ALU response into a MISR signature
// and checks it against an expected value once the programmed vector count is reached.
module cve2_alu_resp_monitor #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7,
    parameter logic [31:0] SIG_SEED  = 32'hFFFFFFFF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vec_i,
    input  logic [31:0]      exp_sig_i,
    input  logic             vec_valid_i,
    input  logic [31:0]      result_i,
    input  logic [31:0]      adder_result_i,
    input  logic             comparison_result_i,
    input  logic             is_equal_result_i,
    input  logic [1:0]       imd_val_we_i,
    input  logic [67:0]      imd_val_d_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [31:0]      signature_o,
    output logic [CNT_W-1:0] vec_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [31:0]      exp_q, exp_d;
    logic             pass_q, pass_d;

    logic [31:0] fold_w;
    logic [31:0] sig_step;

    always_comb begin
        fold_w = result_i
               ^ {adder_result_i[23:0], adder_result_i[31:24]}
               ^ {30'b0, comparison_result_i, is_equal_result_i};
        if (imd_val_we_i[0]) begin
            fold_w = fold_w ^ imd_val_d_i[31:0];
        end
        if (imd_val_we_i[1]) begin
            fold_w = fold_w ^ imd_val_d_i[65:34];
        end
        sig_step = {sig_q[30:0], 1'b0}
                 ^ (sig_q[31] ? MISR_POLY : 32'h0)
                 ^ fold_w;
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A start wins over a coincident vector: that vector is dropped.
                if (start_i) begin
                    num_d   = num_vec_i;
                    exp_d   = exp_sig_i;
                    sig_d   = SIG_SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = (num_vec_i == '0) ? CHECK : RUN;
                end
            end
            RUN: begin
                if (vec_valid_i) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == num_q - CNT_W'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                pass_d  = (sig_q == exp_q);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sig_q   <= SIG_SEED;
            cnt_q   <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    assign busy_o      = (state_q == RUN) || (state_q == CHECK);
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign signature_o = sig_q;
    assign vec_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cve2_alu_resp_monitor.sv
// Bench for cve2_alu_resp_monitor: table-driven runs checked against a MISR
// reference model through a scoreboard queue, plus hand-written corner cases.
module tb_cve2_alu_resp_monitor;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [CNT_W-1:0] num_vec_i;
    logic [31:0]      exp_sig_i;
    logic             vec_valid_i;
    logic [31:0]      result_i;
    logic [31:0]      adder_result_i;
    logic             comparison_result_i;
    logic             is_equal_result_i;
    logic [1:0]       imd_val_we_i;
    logic [67:0]      imd_val_d_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [31:0]      signature_o;
    logic [CNT_W-1:0] vec_cnt_o;

    cve2_alu_resp_monitor #(
        .CNT_W    (CNT_W),
        .MISR_POLY(POLY),
        .SIG_SEED (SEED)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start_i),
        .num_vec_i          (num_vec_i),
        .exp_sig_i          (exp_sig_i),
        .vec_valid_i        (vec_valid_i),
        .result_i           (result_i),
        .adder_result_i     (adder_result_i),
        .comparison_result_i(comparison_result_i),
        .is_equal_result_i  (is_equal_result_i),
        .imd_val_we_i       (imd_val_we_i),
        .imd_val_d_i        (imd_val_d_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .pass_o             (pass_o),
        .signature_o        (signature_o),
        .vec_cnt_o          (vec_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] a;
        logic        c;
        logic        e;
        logic [1:0]  we;
        logic [67:0] imd;
    } alu_t;

    typedef struct {
        int          nv;
        int          kind;
        bit          gapped;
        logic [31:0] exp_in;
        bit          use_model;
        bit          flip;
        bit          chk_const;
        logic [31:0] fconst;
        bit          exp_pass;
    } vec_t;

    logic [31:0] msig;
    int          mcnt;
    logic [31:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic alu_t gen(input int kind, input int i);
        alu_t v;
        logic [31:0] iv;
        iv = 32'(i);
        v.r = 0; v.a = 0; v.c = 0; v.e = 0; v.we = 0; v.imd = 0;
        case (kind)
            1, 3: begin
                v.r   = 32'h9E3779B9 * (iv + 1);
                v.a   = 32'hA5A50F0F ^ (iv << 4);
                v.c   = iv[0];
                v.e   = iv[1];
                v.imd = {2'b10, v.r ^ 32'h0F0F1234, 2'b01, v.a + iv};
                v.we  = (kind == 3) ? iv[1:0] : 2'b00;
            end
            2: begin
                v.we  = 2'b11;
                v.imd = {34'h3_0000_00FF, 34'h0_0000_00FF};
            end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s, input alu_t v);
        logic [31:0] w;
        logic [31:0] n;
        w = v.r ^ ((v.a << 8) | (v.a >> 24)) ^ {30'b0, v.c, v.e};
        if (v.we[0]) w = w ^ v.imd[31:0];
        if (v.we[1]) w = w ^ v.imd[65:34];
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ w;
    endfunction

    task automatic apply(input alu_t v);
        result_i            = v.r;
        adder_result_i      = v.a;
        comparison_result_i = v.c;
        is_equal_result_i   = v.e;
        imd_val_we_i        = v.we;
        imd_val_d_i         = v.imd;
    endtask

    task automatic do_start(input int nv, input logic [31:0] ex);
        start_i   = 1'b1;
        num_vec_i = CNT_W'(nv);
        exp_sig_i = ex;
        @(negedge clk);
        start_i = 1'b0;
        msig = SEED;
        mcnt = 0;
        chk("start_sig", signature_o, SEED);
        chk("start_cnt", 32'(vec_cnt_o), 0);
        chk("start_done", 32'(done_o), 0);
    endtask

    task automatic send(input alu_t v, input int gap);
        apply(v);
        vec_valid_i = 1'b1;
        msig = step(msig, v);
        sb_q.push_back(msig);
        @(negedge clk);
        vec_valid_i = 1'b0;
        mcnt++;
        chk("vec_sig", signature_o, sb_q.pop_front());
        chk("vec_cnt", 32'(vec_cnt_o), 32'(mcnt));
        for (int g = 0; g < gap; g++) begin
            apply(gen(1, 77 + g));
            @(negedge clk);
            chk("gap_sig", signature_o, msig);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done_o), 1);
        chk("done_busy", 32'(busy_o), 0);
    endtask

    vec_t tbl[7];
    int   gaps[3] = '{0, 2, 5};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s;
        logic [31:0] ex;
        tbl[0] = '{1, 0, 0, 32'hFB3EE249, 0, 0, 1, 32'hFB3EE249, 1};
        tbl[1] = '{1, 0, 0, 32'h00000000, 0, 0, 1, 32'hFB3EE249, 0};
        tbl[2] = '{1, 2, 0, 32'hFB3EE249, 0, 0, 1, 32'hFB3EE249, 1};
        tbl[3] = '{3, 1, 0, 32'h0, 1, 0, 0, 32'h0, 1};
        tbl[4] = '{3, 1, 1, 32'h0, 1, 0, 0, 32'h0, 1};
        tbl[5] = '{5, 1, 0, 32'h0, 1, 1, 0, 32'h0, 0};
        tbl[6] = '{8, 3, 1, 32'h0, 1, 0, 0, 32'h0, 1};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        num_vec_i   = '0;
        exp_sig_i   = '0;
        vec_valid_i = 1'b0;
        apply(gen(0, 0));
        repeat (2) @(negedge clk);
        chk("rst_sig", signature_o, SEED);
        chk("rst_cnt", 32'(vec_cnt_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_pass", 32'(pass_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // vector ignored while idle
        vec_valid_i = 1'b1;
        apply(gen(1, 3));
        @(negedge clk);
        vec_valid_i = 1'b0;
        chk("idle_vec_sig", signature_o, SEED);
        chk("idle_vec_cnt", 32'(vec_cnt_o), 0);

        // zero-length run
        start_i   = 1'b1;
        num_vec_i = '0;
        exp_sig_i = SEED;
        @(negedge clk);
        start_i = 1'b0;
        chk("nv0_busy", 32'(busy_o), 1);
        chk("nv0_done", 32'(done_o), 0);
        @(negedge clk);
        chk("nv0_done2", 32'(done_o), 1);
        chk("nv0_busy2", 32'(busy_o), 0);
        chk("nv0_pass", 32'(pass_o), 1);
        chk("nv0_sig", signature_o, SEED);
        chk("nv0_cnt", 32'(vec_cnt_o), 0);

        for (int t = 0; t < 7; t++) begin
            s = SEED;
            for (int i = 0; i < tbl[t].nv; i++) s = step(s, gen(tbl[t].kind, i));
            ex = tbl[t].use_model ? (s ^ 32'(tbl[t].flip)) : tbl[t].exp_in;
            do_start(tbl[t].nv, ex);
            chk("tbl_busy", 32'(busy_o), 1);
            for (int i = 0; i < tbl[t].nv; i++)
                send(gen(tbl[t].kind, i), tbl[t].gapped ? gaps[i % 3] : 0);
            wait_done();
            chk("tbl_pass", 32'(pass_o), 32'(tbl[t].exp_pass));
            chk("tbl_cnt", 32'(vec_cnt_o), 32'(tbl[t].nv));
            chk("tbl_sig", signature_o, s);
            if (tbl[t].chk_const) chk("tbl_const", signature_o, tbl[t].fconst);
        end

        // vectors in DONE are ignored and outputs stay frozen
        s = signature_o;
        vec_valid_i = 1'b1;
        apply(gen(1, 9));
        repeat (2) @(negedge clk);
        vec_valid_i = 1'b0;
        chk("done_vec_sig", signature_o, s);
        chk("done_vec_cnt", 32'(vec_cnt_o), 8);
        chk("done_vec_done", 32'(done_o), 1);
        chk("done_vec_pass", 32'(pass_o), 1);

        // start coinciding with a vector in DONE: vector dropped, pass cleared
        s = step(SEED, gen(1, 0));
        vec_valid_i = 1'b1;
        apply(gen(1, 5));
        do_start(1, s);
        vec_valid_i = 1'b0;
        chk("restart_pass", 32'(pass_o), 0);
        chk("restart_busy", 32'(busy_o), 1);
        send(gen(1, 0), 0);
        wait_done();
        chk("restart_sig", signature_o, s);
        chk("restart_ok", 32'(pass_o), 1);

        // start during RUN is ignored
        s = SEED;
        for (int i = 0; i < 3; i++) s = step(s, gen(3, i + 4));
        do_start(3, s);
        send(gen(3, 4), 0);
        start_i   = 1'b1;
        num_vec_i = CNT_W'(1);
        exp_sig_i = 32'h0;
        send(gen(3, 5), 1);
        start_i = 1'b0;
        send(gen(3, 6), 0);
        wait_done();
        chk("runstart_cnt", 32'(vec_cnt_o), 3);
        chk("runstart_pass", 32'(pass_o), 1);

        // reset mid-run discards partial signature
        do_start(4, 32'h0);
        send(gen(1, 0), 0);
        send(gen(1, 1), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sig", signature_o, SEED);
        chk("midrst_cnt", 32'(vec_cnt_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_done", 32'(done_o), 0);
        chk("midrst_pass", 32'(pass_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s = step(SEED, gen(1, 0));
        do_start(1, s);
        send(gen(1, 0), 0);
        wait_done();
        chk("postrst_sig", signature_o, s);
        chk("postrst_pass", 32'(pass_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
